// File: rtl/riscv_lsu_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_lsu_if                                                 |
// | Description : Data-memory port of the load/store unit. The LSU drives the  |
// |               request side (req/we/be/addr/wdata). Memory answers with     |
// |               grant, response-valid and read data.                         |
// | Modports    : master - LSU side, slave - memory side                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface riscv_lsu_if;
  logic        data_req_o;     // memory request
  logic        data_we_o;      // 1 = write
  logic [3:0]  data_be_o;      // byte enables
  logic [31:0] data_addr_o;    // word-aligned address
  logic [31:0] data_wdata_o;   // lane-replicated store data
  logic        data_gnt_i;     // request accepted
  logic        data_rvalid_i;  // read data valid / write acknowledge
  logic [31:0] data_rdata_i;   // read data

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/riscv_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_lsu                                                    |
// | Description : Load/store unit controller between execute stage and data   |
// |               memory. Runs the req/gnt/rvalid handshake, builds byte      |
// |               enables and replicated store data, extends load data,       |
// |               stalls the core, and flags misaligned/illegal accesses and  |
// |               memory timeouts.                                            |
// | Ports       : clk_i, arstn_i        clock, async active-low reset          |
// |               lsu_req_i/we/size/addr/wdata   operation from the decoder    |
// |               lsu_rdata_o           extended load result (DONE cycle)      |
// |               lsu_stall_o           freeze the core                        |
// |               lsu_misalign_o        DONE pulse: misaligned / illegal size  |
// |               lsu_fault_o           DONE pulse: memory timeout             |
// |               mem                   data-memory port (riscv_lsu_if.master) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk_i,
  input  wire logic        arstn_i,
  input  wire logic        lsu_req_i,
  input  wire logic        lsu_we_i,
  input  wire logic [2:0]  lsu_size_i,
  input  wire logic [31:0] lsu_addr_i,
  input  wire logic [31:0] lsu_wdata_i,
  output logic      [31:0] lsu_rdata_o,
  output logic             lsu_stall_o,
  output logic             lsu_misalign_o,
  output logic             lsu_fault_o,
  riscv_lsu_if.master      mem
);

  // Count value reached during the last permitted REQ/WAIT cycle.
  localparam logic [15:0] c_cnt_last = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_we;
  logic [2:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        r_misalign;
  logic        r_fault;

  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_last;

  // Legality of the incoming request: illegal size codes, unsigned stores
  // and misaligned halfword/word addresses all end in a misalign report.
  always_comb begin
    w_bad = 1'b0;
    case (lsu_size_i)
      3'd0:    w_bad = 1'b0;
      3'd1:    w_bad = lsu_addr_i[0];
      3'd2:    w_bad = |lsu_addr_i[1:0];
      3'd4:    w_bad = lsu_we_i;
      3'd5:    w_bad = lsu_we_i | lsu_addr_i[0];
      default: w_bad = 1'b1;
    endcase
  end

  // Byte enables and store data; size[1:0] selects byte/half/word for both
  // signed and unsigned codes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = lsu_wdata_i;
    case (lsu_size_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << lsu_addr_i[1:0];
        w_wdata = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << lsu_addr_i[1:0];
        w_wdata = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = lsu_wdata_i;
      end
    endcase
  end

  // Load extraction uses the size/offset captured at request time, since the
  // response arrives after the decoder inputs may no longer be relevant.
  always_comb begin
    w_byte = mem.data_rdata_i[{r_off, 3'b000} +: 8];
    w_half = mem.data_rdata_i[{r_off[1], 4'b0000} +: 16];
    w_ext  = mem.data_rdata_i;
    case (r_size)
      3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ext = {{16{w_half[15]}}, w_half};
      3'd4:    w_ext = {24'd0, w_byte};
      3'd5:    w_ext = {16'd0, w_half};
      default: w_ext = mem.data_rdata_i;
    endcase
    if (r_we) begin
      w_ext = 32'd0;
    end
  end

  assign w_last = (r_cnt == c_cnt_last);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state          <= S_IDLE;
      r_cnt            <= 16'd0;
      r_we             <= 1'b0;
      r_size           <= 3'd0;
      r_off            <= 2'd0;
      r_rdata          <= 32'd0;
      r_misalign       <= 1'b0;
      r_fault          <= 1'b0;
      mem.data_req_o   <= 1'b0;
      mem.data_we_o    <= 1'b0;
      mem.data_be_o    <= 4'd0;
      mem.data_addr_o  <= 32'd0;
      mem.data_wdata_o <= 32'd0;
    end else begin
      // Result and flags are single-cycle DONE pulses.
      r_rdata    <= 32'd0;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lsu_req_i) begin
            if (w_bad) begin
              r_misalign <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_we             <= lsu_we_i;
              r_size           <= lsu_size_i;
              r_off            <= lsu_addr_i[1:0];
              r_cnt            <= 16'd0;
              mem.data_req_o   <= 1'b1;
              mem.data_we_o    <= lsu_we_i;
              mem.data_be_o    <= w_be;
              mem.data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
              mem.data_wdata_o <= w_wdata;
              r_state          <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 16'd1;
          // Completion beats timeout; a bare grant in the last cycle does not.
          if (mem.data_gnt_i && mem.data_rvalid_i) begin
            mem.data_req_o <= 1'b0;
            r_rdata        <= w_ext;
            r_state        <= S_DONE;
          end else if (w_last) begin
            mem.data_req_o <= 1'b0;
            r_fault        <= 1'b1;
            r_state        <= S_DONE;
          end else if (mem.data_gnt_i) begin
            mem.data_req_o <= 1'b0;
            r_state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (mem.data_rvalid_i) begin
            r_rdata <= w_ext;
            r_state <= S_DONE;
          end else if (w_last) begin
            r_fault <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Gated by reset so every output reads 0 while reset is asserted.
  assign lsu_stall_o    = arstn_i & lsu_req_i & (r_state != S_DONE);
  assign lsu_rdata_o    = r_rdata;
  assign lsu_misalign_o = r_misalign;
  assign lsu_fault_o    = r_fault;

endmodule
`default_nettype wire
